ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage of the five-stage pipeline. It consumes the operand buses and the decoded mult/div operation registered at the ID/EX boundary. It computes 64-bit products and 32-bit quotient/remainder over 33 cycles and holds the architectural HI/LO registers. It drives `busy` to the hazard unit, which stalls any MFHI/MFLO/MTHI/MTLO or new mult/div instruction until the operation finishes.

---
 rtl/ex_muldiv.sv | 151 +++++++++++++++
 tb/tb_ex_muldiv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32-bit multiply/divide unit for the EX stage.
// Holds the architectural HI/LO registers. MULT/MULTU/DIV/DIVU each take
// 33 cycles: 32 CALC iterations followed by one FIX cycle. Operands are
// latched when the operation starts, so the inputs may change while it runs.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   start, op         launch (sampled only in IDLE); 00 MULT 01 MULTU 10 DIV 11 DIVU
//   a, b              rs / rt operands
//   flush             cancel the in-flight operation; HI/LO are left unchanged
//   wr_hi, wr_lo      MTHI / MTLO strobes (IDLE only), data on wr_data
//   busy              high in CALC and FIX
//   done              one-cycle pulse after an operation writes HI/LO
//   hi, lo            HI / LO registers
module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic        is_div;
    logic        sign_a, sign_b;
    logic [31:0] mag_b;
    // Multiply: {partial product high, multiplier}, shifted right each step.
    // Divide:   {partial remainder, dividend/quotient}, shifted left each step.
    logic [63:0] acc;

    logic        accept;
    logic        in_signed;
    logic [31:0] in_mag_a, in_mag_b;
    logic [32:0] mul_sum;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] acc_step;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] res_hi, res_lo;
    logic        commit;

    assign accept    = (state == S_IDLE) && start && !flush;
    assign in_signed = ~op[0];
    assign in_mag_a  = (in_signed && a[31]) ? -a : a;
    assign in_mag_b  = (in_signed && b[31]) ? -b : b;

    // FSM next-state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_CALC;
            S_CALC: begin
                if (flush)             state_nx = S_IDLE;
                else if (cnt == 5'd31) state_nx = S_FIX;
            end
            S_FIX:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != S_IDLE);
            done  <= commit;
        end
    end

    // One iteration of shift-add / restoring division.
    // The shifted remainder acc[63:31] is compared against the divisor; the
    // remainder always stays below the divisor, so 32 bits hold the result.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
        div_ge   = (acc[63:31] >= {1'b0, mag_b});
        div_diff = acc[62:31] - mag_b;
        if (is_div)
            acc_step = div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
        else
            acc_step = {mul_sum, acc[31:1]};
    end

    // Sign correction. Divide by zero yields an all-ones quotient for both
    // DIV and DIVU; the remainder path naturally returns a.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        if (mag_b == 32'd0)
            quo_fix = 32'hFFFF_FFFF;
        else
            quo_fix = (sign_a ^ sign_b) ? -acc[31:0] : acc[31:0];
        rem_fix = sign_a ? -acc[63:32] : acc[63:32];
        res_hi  = is_div ? rem_fix : prod_fix[63:32];
        res_lo  = is_div ? quo_fix : prod_fix[31:0];
    end

    // Flush in FIX beats the write-back.
    assign commit = (state == S_FIX) && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 5'd0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_b  <= 32'd0;
            acc    <= 64'd0;
        end else if (accept) begin
            cnt    <= 5'd0;
            is_div <= op[1];
            sign_a <= in_signed & a[31];
            sign_b <= in_signed & b[31];
            mag_b  <= in_mag_b;
            acc    <= {32'd0, in_mag_a};
        end else if (state == S_CALC) begin
            cnt <= cnt + 5'd1;
            acc <= acc_step;
        end
    end

    // HI/LO: an operation result wins over an MTHI/MTLO issued in the
    // launching cycle because it lands 33 edges later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (state == S_IDLE) begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        reset, start, flush, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] a, b, wr_data;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'd0: return sx * sy;
            2'd1: return ux * uy;
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 2'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                end else begin
                    q = longint'(ux / uy);
                    r = longint'(ux % uy);
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", hi, lo);
            end else begin
                e = exp_q.pop_front();
                check("result_hi", hi, e[63:32]);
                check("result_lo", lo, e[31:0]);
            end
        end
    end

    // Wait for busy to fall, counting busy cycles; operands are scrambled
    // mid-flight and start may be held to prove neither is re-sampled.
    task automatic wait_done(input int n0, input bit hold);
        int n = n0;
        while (busy && n < 100) begin
            n++;
            if (n == 5) begin a = $urandom; b = $urandom; end
            if (n == 25) start = 1'b0;
            @(negedge clk);
        end
        if (!hold) start = 1'b0;
        check("busy_cycles", n, 33);
        @(negedge clk);
        check("done_single_pulse", {31'd0, done}, 32'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit hold);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back(model(o, x, y));
        @(negedge clk);
        if (!hold) start = 1'b0;
        wait_done(0, hold);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 0; flush = 0; wr_hi = 0; wr_lo = 0;
        op = 0; a = 0; b = 0; wr_data = 0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;

        // Directed arithmetic cases
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'd3, 32'd7, 32'd0, 1'b0);
        run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // MTHI/MTLO preload, then flush a DIVU mid-flight
        @(negedge clk); wr_hi = 1; wr_data = 32'h1234;
        @(negedge clk); wr_hi = 0; wr_lo = 1; wr_data = 32'h5678;
        @(negedge clk); wr_lo = 0;
        check("mthi", hi, 32'h1234);
        check("mtlo", lo, 32'h5678);
        op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wr_hi = 1; wr_data = 32'hDEAD;   // ignored while busy
        @(negedge clk); wr_hi = 0;
        repeat (7) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_hi", hi, 32'h1234);
        check("flush_lo", lo, 32'h5678);
        repeat (40) @(negedge clk);

        // start together with flush in IDLE is rejected
        op = 2'd1; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        check("start_flush_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        // start together with MTLO: LO shows the write first, then the product
        op = 2'd1; a = 32'd3; b = 32'd4; start = 1'b1; wr_lo = 1'b1; wr_data = 32'hAAAA;
        exp_q.push_back(64'd12);
        @(negedge clk); start = 1'b0; wr_lo = 1'b0;
        check("mtlo_with_start", lo, 32'hAAAA);
        check("busy_with_mtlo", {31'd0, busy}, 32'd1);
        wait_done(0, 1'b0);

        // Async reset in the middle of a MULT
        run_op(2'd0, 32'h0001_2345, 32'h0000_0777, 1'b0);
        @(negedge clk);
        op = 2'd0; a = 32'h0003_0000; b = 32'h0005_0000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        check("async_reset_hi", hi, 32'd0);
        check("async_reset_lo", lo, 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (40) @(negedge clk);

        // Randomised operations with corner-biased operands
        for (int i = 0; i < 40; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: x = 32'h8000_0000;
                2: y = 32'hFFFF_FFFF;
                3: y = {28'd0, y[3:0]};
                default: ;
            endcase
            run_op(2'($urandom_range(0, 3)), x, y, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
